// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: funct codes, ALU control encodings
// and the decoded control struct carried through the skid buffer.
package alu_issue_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    SEL_SHIFT = 2'b00,
    SEL_SLT   = 2'b01,
    SEL_ARITH = 2'b10,
    SEL_LOGIC = 2'b11
  } alu_sel_e;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_op_e;

  typedef enum logic [1:0] {
    LOG_AND = 2'b00,
    LOG_OR  = 2'b01,
    LOG_NOR = 2'b10,
    LOG_XOR = 2'b11
  } log_op_e;

  typedef struct packed {
    alu_sel_e   alu_selection;
    logic       ariph_op;
    shift_op_e  shift_op;
    log_op_e    log_op;
    logic [4:0] shift_amount;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_NONE = '{
    alu_selection: SEL_SHIFT,
    ariph_op:      1'b0,
    shift_op:      SHIFT_SLL,
    log_op:        LOG_AND,
    shift_amount:  5'd0
  };

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and ALU-control bundle between the upstream decoder, the issue
// stage and the ALU. master = upstream/ALU side, slave = issue stage.
interface alu_issue_if
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [5:0]            in_funct;
  logic [4:0]            in_shamt;
  logic [DATA_WIDTH-1:0] in_rs_data;
  logic [DATA_WIDTH-1:0] in_rt_data;
  logic [4:0]            in_dest;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [1:0]            alu_selection;
  logic                  ariph_op;
  logic [1:0]            shift_op;
  logic [1:0]            log_op;
  logic [4:0]            shift_amount;
  logic [4:0]            out_dest;
  logic                  trap_on_overflow;
  logic                  illegal_instr;

  modport master (
    output in_valid, in_funct, in_shamt, in_rs_data, in_rt_data, in_dest,
    output out_ready,
    input  in_ready,
    input  out_valid, operand_a, operand_b, alu_selection, ariph_op,
    input  shift_op, log_op, shift_amount, out_dest, trap_on_overflow,
    input  illegal_instr
  );

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs_data, in_rt_data, in_dest,
    input  out_ready,
    output in_ready,
    output out_valid, operand_a, operand_b, alu_selection, ariph_op,
    output shift_op, log_op, shift_amount, out_dest, trap_on_overflow,
    output illegal_instr
  );

endinterface

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder producing ALU control fields.
// Variable shifts (sllv/srlv/srav) are legal only with ALU_ISSUE_VARSHIFT_EN.
module alu_funct_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amount,
  output alu_ctrl_t  ctrl,
  output logic       trap_on_overflow,
  output logic       illegal_instr
);

`ifdef ALU_ISSUE_VARSHIFT_EN
  localparam bit VARSHIFT_EN = 1'b1;
`else
  localparam bit VARSHIFT_EN = 1'b0;
`endif

  always_comb begin
    ctrl             = CTRL_NONE;
    trap_on_overflow = 1'b0;
    illegal_instr    = 1'b0;
    case (funct)
      FUNCT_ADD: begin
        ctrl.alu_selection = SEL_ARITH;
        trap_on_overflow   = 1'b1;
      end
      FUNCT_ADDU: ctrl.alu_selection = SEL_ARITH;
      FUNCT_SUB: begin
        ctrl.alu_selection = SEL_ARITH;
        ctrl.ariph_op      = 1'b1;
        trap_on_overflow   = 1'b1;
      end
      FUNCT_SUBU: begin
        ctrl.alu_selection = SEL_ARITH;
        ctrl.ariph_op      = 1'b1;
      end
      // slt reuses the subtractor to form the comparison
      FUNCT_SLT: begin
        ctrl.alu_selection = SEL_SLT;
        ctrl.ariph_op      = 1'b1;
      end
      FUNCT_AND: begin
        ctrl.alu_selection = SEL_LOGIC;
        ctrl.log_op        = LOG_AND;
      end
      FUNCT_OR: begin
        ctrl.alu_selection = SEL_LOGIC;
        ctrl.log_op        = LOG_OR;
      end
      FUNCT_XOR: begin
        ctrl.alu_selection = SEL_LOGIC;
        ctrl.log_op        = LOG_XOR;
      end
      FUNCT_NOR: begin
        ctrl.alu_selection = SEL_LOGIC;
        ctrl.log_op        = LOG_NOR;
      end
      FUNCT_SLL: begin
        ctrl.shift_op     = SHIFT_SLL;
        ctrl.shift_amount = shamt;
      end
      FUNCT_SRL: begin
        ctrl.shift_op     = SHIFT_SRL;
        ctrl.shift_amount = shamt;
      end
      FUNCT_SRA: begin
        ctrl.shift_op     = SHIFT_SRA;
        ctrl.shift_amount = shamt;
      end
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: begin
        if (VARSHIFT_EN) begin
          ctrl.shift_amount = rs_amount;
          ctrl.shift_op     = (funct == FUNCT_SLLV) ? SHIFT_SLL :
                              (funct == FUNCT_SRLV) ? SHIFT_SRL : SHIFT_SRA;
        end else begin
          ctrl.alu_selection = SEL_LOGIC;
          illegal_instr      = 1'b1;
        end
      end
      // unsupported funct still flows through, flagged for the trap logic
      default: begin
        ctrl.alu_selection = SEL_LOGIC;
        illegal_instr      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: funct decode followed by a two-entry skid buffer whose
// main register drives the ALU directly. Optional macro: ALU_ISSUE_VARSHIFT_EN.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  alu_ctrl_t dec_ctrl;
  logic      dec_trap;
  logic      dec_illegal;

  alu_funct_decode u_decode (
    .funct            (bus.in_funct),
    .shamt            (bus.in_shamt),
    .rs_amount        (bus.in_rs_data[4:0]),
    .ctrl             (dec_ctrl),
    .trap_on_overflow (dec_trap),
    .illegal_instr    (dec_illegal)
  );

  logic                  main_valid, skid_valid;
  logic                  main_valid_n, skid_valid_n;
  alu_ctrl_t             main_ctrl, skid_ctrl;
  logic                  main_trap, skid_trap;
  logic                  main_illegal, skid_illegal;
  logic [4:0]            main_dest, skid_dest;
  logic [DATA_WIDTH-1:0] main_a, main_b, skid_a, skid_b;

  logic accept, retire;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = bus.in_valid & ~skid_valid;
  assign retire = main_valid & bus.out_ready;

  // skid_valid implies main_valid, so accept never collides with a skid drain
  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!main_valid || retire) begin
      if (skid_valid) begin
        load_main_skid = 1'b1;
        main_valid_n   = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        load_main_in = 1'b1;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_ctrl    <= CTRL_NONE;
      skid_trap    <= 1'b0;
      skid_illegal <= 1'b0;
      skid_dest    <= '0;
      skid_a       <= '0;
      skid_b       <= '0;
    end else if (load_skid) begin
      skid_ctrl    <= dec_ctrl;
      skid_trap    <= dec_trap;
      skid_illegal <= dec_illegal;
      skid_dest    <= bus.in_dest;
      skid_a       <= bus.in_rs_data;
      skid_b       <= bus.in_rt_data;
    end
  end

  // flush only clears valid bits; payload registers keep stale contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl    <= CTRL_NONE;
      main_trap    <= 1'b0;
      main_illegal <= 1'b0;
      main_dest    <= '0;
      main_a       <= '0;
      main_b       <= '0;
    end else if (load_main_skid) begin
      main_ctrl    <= skid_ctrl;
      main_trap    <= skid_trap;
      main_illegal <= skid_illegal;
      main_dest    <= skid_dest;
      main_a       <= skid_a;
      main_b       <= skid_b;
    end else if (load_main_in) begin
      main_ctrl    <= dec_ctrl;
      main_trap    <= dec_trap;
      main_illegal <= dec_illegal;
      main_dest    <= bus.in_dest;
      main_a       <= bus.in_rs_data;
      main_b       <= bus.in_rt_data;
    end
  end

  assign bus.in_ready         = ~skid_valid;
  assign bus.out_valid        = main_valid;
  assign bus.operand_a        = main_a;
  assign bus.operand_b        = main_b;
  assign bus.alu_selection    = main_ctrl.alu_selection;
  assign bus.ariph_op         = main_ctrl.ariph_op;
  assign bus.shift_op         = main_ctrl.shift_op;
  assign bus.log_op           = main_ctrl.log_op;
  assign bus.shift_amount     = main_ctrl.shift_amount;
  assign bus.out_dest         = main_dest;
  assign bus.trap_on_overflow = main_trap;
  assign bus.illegal_instr    = main_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic checked
// against a FIFO-of-instructions reference model with a table-driven decoder.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
  } txn_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       ariph;
    logic [1:0] shift;
    logic [1:0] log;
    logic [4:0] amt;
    logic       trap;
    logic       ill;
  } exp_t;

  txn_t model_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t expected_ctrl(txn_t t);
    exp_t e;
    e = '0;
    case (t.funct)
      6'h20: begin e.sel = 2'b10; e.trap = 1'b1; end
      6'h21: e.sel = 2'b10;
      6'h22: begin e.sel = 2'b10; e.ariph = 1'b1; e.trap = 1'b1; end
      6'h23: begin e.sel = 2'b10; e.ariph = 1'b1; end
      6'h2A: begin e.sel = 2'b01; e.ariph = 1'b1; end
      6'h24: e.sel = 2'b11;
      6'h25: begin e.sel = 2'b11; e.log = 2'b01; end
      6'h26: begin e.sel = 2'b11; e.log = 2'b11; end
      6'h27: begin e.sel = 2'b11; e.log = 2'b10; end
      6'h00: e.amt = t.shamt;
      6'h02: begin e.shift = 2'b01; e.amt = t.shamt; end
      6'h03: begin e.shift = 2'b10; e.amt = t.shamt; end
`ifdef ALU_ISSUE_VARSHIFT_EN
      6'h04: e.amt = t.rs[4:0];
      6'h06: begin e.shift = 2'b01; e.amt = t.rs[4:0]; end
      6'h07: begin e.shift = 2'b10; e.amt = t.rs[4:0]; end
`endif
      default: begin e.sel = 2'b11; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_operand_a"}, bus.operand_a, 32'd0);
    check({tag, "_operand_b"}, bus.operand_b, 32'd0);
    check({tag, "_ctrl"}, 32'({bus.alu_selection, bus.ariph_op, bus.shift_op,
                              bus.log_op, bus.shift_amount}), 32'd0);
    check({tag, "_dest"}, 32'(bus.out_dest), 32'd0);
    check({tag, "_flags"}, 32'({bus.trap_on_overflow, bus.illegal_instr}), 32'd0);
  endtask

  task automatic check_output();
    exp_t e;
    check("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      e = expected_ctrl(model_q[0]);
      check("operand_a", bus.operand_a, model_q[0].rs);
      check("operand_b", bus.operand_b, model_q[0].rt);
      check("out_dest", 32'(bus.out_dest), 32'(model_q[0].dest));
      check("alu_selection", 32'(bus.alu_selection), 32'(e.sel));
      check("ariph_op", 32'(bus.ariph_op), 32'(e.ariph));
      check("shift_op", 32'(bus.shift_op), 32'(e.shift));
      check("log_op", 32'(bus.log_op), 32'(e.log));
      check("shift_amount", 32'(bus.shift_amount), 32'(e.amt));
      check("trap_on_overflow", 32'(bus.trap_on_overflow), 32'(e.trap));
      check("illegal_instr", 32'(bus.illegal_instr), 32'(e.ill));
    end
  endtask

  // Called just after a falling edge: check, drive, advance model, clock once.
  task automatic step(input logic v, input logic [5:0] f, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                      input logic ordy, input logic fl, output logic accepted);
    txn_t t;
    logic ret;
    check_output();
    bus.in_valid   = v;
    bus.in_funct   = f;
    bus.in_shamt   = sh;
    bus.in_rs_data = a;
    bus.in_rt_data = b;
    bus.in_dest    = d;
    bus.out_ready  = ordy;
    flush          = fl;
    t = '{funct: f, shamt: sh, rs: a, rt: b, dest: d};
    accepted = v && (model_q.size() < 2);
    ret      = (model_q.size() > 0) && ordy;
    if (fl) begin
      model_q.delete();
    end else begin
      if (ret) void'(model_q.pop_front());
      if (accepted) model_q.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 6'h00, 5'd0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, acc);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        acc;
    logic [31:0] res;
    int          cyc;
    logic [5:0]  stream_funct [4];
    logic [5:0]  funct_pool [18];

    stream_funct = '{6'h20, 6'h25, 6'h02, 6'h2A};
    funct_pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                   6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01, 6'h3F, 6'h18};

    bus.in_valid = 1'b0; bus.in_funct = '0; bus.in_shamt = '0;
    bus.in_rs_data = '0; bus.in_rt_data = '0; bus.in_dest = '0;
    bus.out_ready = 1'b0;

    #1 reset = 1'b1;
    #3 check_reset_zero("reset_async");
    @(negedge clk);
    check_reset_zero("reset_held");
    reset = 1'b0;

    // sub 7 - 9
    step(1'b1, 6'h22, 5'd0, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, acc);
    check("sub_alu_result", bus.operand_a - bus.operand_b, 32'hFFFF_FFFE);
    check("sub_trap", 32'(bus.trap_on_overflow), 32'd1);
    idle(1'b1);

    // four back-to-back entries with a two-cycle downstream stall
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      acc = 1'b0;
      for (int k = 0; k < 8 && !acc; k++) begin
        step(1'b1, stream_funct[i], 5'(i + 1), 32'(100 + i), 32'(200 + i), 5'(i + 8),
             (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1, 1'b0, acc);
        cyc++;
      end
      check("stream_accepted", 32'(acc), 32'd1);
    end
    repeat (3) idle(1'b1);

    // sra by 7 of 0x80000000
    step(1'b1, 6'h03, 5'd7, 32'd0, 32'h8000_0000, 5'd1, 1'b1, 1'b0, acc);
    res = $unsigned($signed(bus.operand_b) >>> bus.shift_amount);
    check("sra_alu_result", res, 32'hFF00_0000);
    idle(1'b1);

    // sllv with rs = 3
    step(1'b1, 6'h04, 5'd0, 32'd3, 32'd5, 5'd2, 1'b1, 1'b0, acc);
`ifdef ALU_ISSUE_VARSHIFT_EN
    check("sllv_amount", 32'(bus.shift_amount), 32'd3);
    check("sllv_illegal", 32'(bus.illegal_instr), 32'd0);
`else
    check("sllv_illegal", 32'(bus.illegal_instr), 32'd1);
    check("sllv_sel", 32'(bus.alu_selection), 32'd3);
`endif
    idle(1'b1);

    // flush with both entries held and a new entry offered
    step(1'b1, 6'h21, 5'd0, 32'h11, 32'h22, 5'd4, 1'b0, 1'b0, acc);
    step(1'b1, 6'h24, 5'd0, 32'h33, 32'h44, 5'd5, 1'b0, 1'b0, acc);
    check("flush_pre_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 6'h26, 5'd0, 32'hDEAD, 32'hBEEF, 5'd6, 1'b0, 1'b1, acc);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) idle(1'b1);

    // reset asserted while stalled with both entries held
    step(1'b1, 6'h20, 5'd0, 32'h55, 32'h66, 5'd7, 1'b0, 1'b0, acc);
    step(1'b1, 6'h22, 5'd0, 32'h77, 32'h88, 5'd9, 1'b0, 1'b0, acc);
    check_output();
    #2 reset = 1'b1;
    #1 check_reset_zero("reset_mid_stall");
    model_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_zero("reset_mid_stall_held");
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                      : funct_pool[$urandom_range(0, 17)];
      step($urandom_range(0, 3) != 0, f, 5'($urandom), $urandom, $urandom, 5'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
    end
    repeat (3) idle(1'b1);
    check_output();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipeline stage directly upstream of `alu`: accepts decoded R-type instructions (funct, shamt, register data, destination) over a valid/ready handshake. It translates funct into the ALU control fields `alu_selection`, `ariph_op`, `shift_op`, `log_op` and `shift_amount`, then registers them with the operands. A two-entry skid buffer gives full throughput with fully registered `in_ready` and outputs; the registered outputs drive `alu` ports directly.

## Interface
- `DATA_WIDTH`, 32, operand width; fixed at 32 to match `alu`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `flush`  in  1  synchronous kill of all held entries
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  stage can accept; registered
- `in_funct`  in  6  R-type funct field
- `in_shamt`  in  5  instruction shamt field
- `in_rs_data`  in  32  rs register value
- `in_rt_data`  in  32  rt register value
- `in_dest`  in  5  rd index, passed through
- `out_valid`  out  1  entry presented to `alu`
- `out_ready`  in  1  downstream consumes entry
- `operand_a`, `operand_b`  out  32 each  rs data, rt data
- `alu_selection`  out  2  00 shift, 01 slt, 10 arith, 11 logic
- `ariph_op`  out  1  0 add, 1 subtract
- `shift_op`  out  2  00 sll, 01 srl, 10 sra
- `log_op`  out  2  00 and, 01 or, 10 nor, 11 xor
- `shift_amount`  out  5  raw left/right amount; `alu` handles left inversion itself
- `out_dest`  out  5  rd index
- `trap_on_overflow`  out  1  set for add/sub; clear for addu/subu
- `illegal_instr`  out  1  funct not supported

## Operation
- Decode: add 0x20 and addu 0x21 give sel 10, ariph 0. sub 0x22 and subu 0x23 give sel 10, ariph 1. slt 0x2A gives sel 01, ariph 1.
- Logic ops use sel 11: and 0x24 log 00, or 0x25 log 01, xor 0x26 log 11, nor 0x27 log 10.
- Shift ops use sel 00 with `shift_amount` = `in_shamt`: sll 0x00 shift 00, srl 0x02 shift 01, sra 0x03 shift 10.
- `trap_on_overflow` = 1 for add and sub only.
- Any other funct: `illegal_instr`=1, sel 11, log 00, ariph 0, shift 00, amount 0. The entry still flows through with the handshake.
- Unused fields for any decoded op drive 0. `shift_op` 11 is never generated.
- Skid buffer: one main register drives the outputs and one skid register catches data when downstream stalls.
  - `in_ready` = NOT skid_valid.
  - Accept on `in_valid & in_ready`; present on `out_valid`; retire on `out_valid & out_ready`.
  - Accept while main is empty or retiring: data goes to main.
  - Accept while main is held: data goes to skid.
  - Main retires while skid is full: skid moves to main.
- Simultaneous accept and retire with skid empty: new entry replaces main in the same edge, so `out_valid` stays 1.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 entry per cycle while `out_ready`=1.
- `in_ready` falls the cycle after an entry lands in skid. It rises the cycle after skid drains.
- Reset values: `out_valid` 0, `in_ready` 1. All data and control outputs 0, including `illegal_instr` and `trap_on_overflow`.
- Reset mid-stall discards both entries.
- `flush` clears main and skid valid bits at the next edge, and any entry accepted in that same cycle is dropped. Next cycle: `out_valid` 0, `in_ready` 1. Data registers keep stale contents.
- `flush` takes priority over accept and retire.
- Outputs are stable while `out_valid & ~out_ready`.

## Configuration
- `ALU_ISSUE_VARSHIFT_EN` defined: sllv 0x04, srlv 0x06 and srav 0x07 decode as sel 00 with shift 00, 01 and 10 respectively. For these, `shift_amount` = `in_rs_data[4:0]`.
- `ALU_ISSUE_VARSHIFT_EN` undefined: 0x04, 0x06 and 0x07 are illegal.

## Structure
- Package `alu_issue_pkg` holds:
  - funct constants (FUNCT_ADD … FUNCT_SLT);
  - the `alu_selection`, `shift_op` and `log_op` encodings;
  - a packed struct of the decoded control fields, stored in both buffer registers.
- One combinational sub-module `alu_funct_decode`, which maps funct, shamt and rs to the control struct plus the illegal and trap flags. The macro is checked only there.
- Top holds the skid buffer and handshake.

## Test plan
- Reset asserted mid-stream: outputs all zero, `in_ready` 1, `out_valid` 0 immediately and while held.
- sub (0x22), rs=7, rt=9, `out_ready`=1: next cycle sel 10, ariph 1, operands 7/9, trap 1. Driving `alu` gives result 0xFFFFFFFE.
- Back-to-back stream of 4 entries, `out_ready` low for cycles 2–3: `in_ready` drops one cycle after the skid fills. No entry is lost or duplicated, and the output order matches the input order.
- sra (0x03), shamt=7, rt=0x80000000: sel 00, shift 10, amount 7. `alu` result 0xFF000000.
- funct 0x04 with rs=3: macro on gives sel 00, shift 00, amount 3. Macro off gives `illegal_instr`=1 and sel 11.
- `flush` with both entries held and `in_valid`=1: next cycle `out_valid` 0, `in_ready` 1. The input presented in the flush cycle never appears on the outputs.
